// File: rtl/pkt_fifo_router_core_pkg.sv
// Shared constants, port-id encoding and FSM state types for the packet-slot router.
package pkt_fifo_router_core_pkg;

  localparam int DEF_PTR_SZ    = 2;
  localparam int DEF_PTR_IN_SZ = 4;
  localparam int DEF_UWIDTH    = 8;
  localparam int DEST_ID_OFS   = 1;

  typedef enum logic [1:0] {PORT_FREE = 2'd0, PORT_P1 = 2'd1, PORT_P2 = 2'd2, PORT_P3 = 2'd3} port_id_e;
  typedef enum logic [1:0] {D_IDLE, D_READ_DEST, D_ROUTE} disp_state_e;
  typedef enum logic [1:0] {Q_IDLE, Q_ACTIVE, Q_RELEASE} port_state_e;

endpackage

// File: rtl/pkt_fifo_router_core_map.sv
// Slot-ownership map: 0 = free, 1..3 = owning port; cleared on reset.
module pkt_fifo_router_core_map
  import pkt_fifo_router_core_pkg::*;
#(
  parameter int PTR_SZ = DEF_PTR_SZ
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [PTR_SZ-1:0] waddr,
  input  port_id_e          wdata,
  input  logic [PTR_SZ-1:0] raddr,
  output port_id_e          rdata
);

  port_id_e entries [2**PTR_SZ];

  // NOTE: sequential state uses <= so every register samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**PTR_SZ; i++) entries[i] <= PORT_FREE;
    end else if (we) begin
      entries[waddr] <= wdata;
    end
  end

  assign rdata = entries[raddr];

endmodule

// File: rtl/pkt_fifo_router_core_mem.sv
// Slot memory: one synchronous write port, three output read ports and a gated dispatcher read port.
module pkt_fifo_router_core_mem
  import pkt_fifo_router_core_pkg::*;
#(
  parameter int PTR_SZ    = DEF_PTR_SZ,
  parameter int PTR_IN_SZ = DEF_PTR_IN_SZ,
  parameter int UWIDTH    = DEF_UWIDTH
) (
  input  logic                          clk,
  input  logic                          write_en,
  input  logic [PTR_SZ-1:0]             waddr,
  input  logic [PTR_IN_SZ-1:0]          waddr_in,
  input  logic [UWIDTH-1:0]             wdata,
  input  logic [2:0][PTR_SZ-1:0]        raddr,
  input  logic [2:0][PTR_IN_SZ-1:0]     raddr_in,
  output logic [2:0][UWIDTH-1:0]        rdata,
  input  logic                          uread_en,
  input  logic [PTR_SZ-1:0]             uaddr,
  input  logic [PTR_IN_SZ-1:0]          uaddr_in,
  output logic [UWIDTH-1:0]             udata
);

  logic [UWIDTH-1:0] mem [2**PTR_SZ][2**PTR_IN_SZ];

  // NOTE: packet storage has no reset; ownership is tracked by the slot map, so stale bytes are never consumed.
  always_ff @(posedge clk) begin
    if (write_en) mem[waddr][waddr_in] <= wdata;
  end

  always_comb begin
    for (int i = 0; i < 3; i++) rdata[i] = mem[raddr[i]][raddr_in[i]];
  end

  assign udata = uread_en ? mem[uaddr][uaddr_in] : '0;

endmodule

// File: rtl/pkt_fifo_router_core_port_queue.sv
// Per-port slot queue with IDLE/ACTIVE/RELEASE ownership FSM.
module pkt_fifo_router_core_port_queue
  import pkt_fifo_router_core_pkg::*;
#(
  parameter int PTR_SZ = DEF_PTR_SZ
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [PTR_SZ-1:0] push_slot,
  input  logic              done,
  input  logic              grant,
  output logic              en,
  output logic [PTR_SZ-1:0] slot,
  output logic              rel_req
);

  localparam logic [PTR_SZ:0] IDX_ONE = 1;

  logic [PTR_SZ-1:0] fifo [2**PTR_SZ];
  logic [PTR_SZ:0]   ridx, widx;
  logic              empty, pop;
  port_state_e       state, state_nxt;

  assign empty = (ridx == widx);
  assign pop   = (state == Q_RELEASE) && grant;

  always_ff @(posedge clk) begin
    if (push) fifo[widx[PTR_SZ-1:0]] <= push_slot;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ridx <= '0;
      widx <= '0;
    end else begin
      if (push) widx <= widx + IDX_ONE;
      if (pop)  ridx <= ridx + IDX_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= Q_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      Q_IDLE:    if (!empty) state_nxt = Q_ACTIVE;
      Q_ACTIVE:  if (done)   state_nxt = Q_RELEASE;
      Q_RELEASE: if (grant)  state_nxt = Q_IDLE;
      default:               state_nxt = Q_IDLE;
    endcase
  end

  always_comb begin
    en      = (state == Q_ACTIVE);
    rel_req = (state == Q_RELEASE);
    slot    = (state == Q_IDLE) ? '0 : fifo[ridx[PTR_SZ-1:0]];
  end

endmodule

// File: rtl/pkt_fifo_router_core.sv
// Packet-slot FIFO router: dispatches packets by dest_id to three ports and frees slots in order.
// Optional build macro DEST_DROP_EN drops packets whose dest_id[5:4] is 00 instead of routing them to port 1.
module pkt_fifo_router_core
  import pkt_fifo_router_core_pkg::*;
#(
  parameter int PTR_SZ    = DEF_PTR_SZ,
  parameter int PTR_IN_SZ = DEF_PTR_IN_SZ,
  parameter int UWIDTH    = DEF_UWIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 write_en,
  input  logic [PTR_SZ-1:0]    waddr,
  input  logic [PTR_IN_SZ-1:0] waddr_in,
  input  logic [UWIDTH-1:0]    wdata,
  input  logic [PTR_SZ:0]      rq2_wptr,
  input  logic                 read_port_1_done,
  input  logic                 read_port_2_done,
  input  logic                 read_port_3_done,
  input  logic [PTR_IN_SZ-1:0] raddr_in_port_1,
  input  logic [PTR_IN_SZ-1:0] raddr_in_port_2,
  input  logic [PTR_IN_SZ-1:0] raddr_in_port_3,
  output logic                 read_port_1_en,
  output logic                 read_port_2_en,
  output logic                 read_port_3_en,
  output logic [PTR_SZ-1:0]    raddr_port_1,
  output logic [PTR_SZ-1:0]    raddr_port_2,
  output logic [PTR_SZ-1:0]    raddr_port_3,
  output logic [UWIDTH-1:0]    rdata_port_1,
  output logic [UWIDTH-1:0]    rdata_port_2,
  output logic [UWIDTH-1:0]    rdata_port_3,
  output logic [PTR_SZ:0]      rptr_gray
);

  localparam logic [PTR_SZ:0] PTR_ONE = 1;

  disp_state_e              dstate, dstate_nxt;
  logic [PTR_SZ:0]          vrptr, rptr, rptr_nxt;
  logic [UWIDTH-1:0]        dest_id, udata;
  logic                     uread_en, drop, route_wr, map_we;
  logic [PTR_SZ-1:0]        uaddr, map_waddr;
  logic [PTR_IN_SZ-1:0]     uaddr_in;
  port_id_e                 out_port, map_wdata, map_rdata;
  logic [2:0]               push, done, en, rel_req, grant;
  logic [2:0][PTR_SZ-1:0]   slot;
  logic [2:0][PTR_IN_SZ-1:0] raddr_in;
  logic [2:0][UWIDTH-1:0]   rdata;

  assign done     = {read_port_3_done, read_port_2_done, read_port_1_done};
  assign raddr_in = {raddr_in_port_3, raddr_in_port_2, raddr_in_port_1};

  always_ff @(posedge clk) begin
    if (rst) dstate <= D_IDLE;
    else     dstate <= dstate_nxt;
  end

  always_comb begin
    dstate_nxt = dstate;
    case (dstate)
      D_IDLE:      if (vrptr != rq2_wptr) dstate_nxt = D_READ_DEST;
      D_READ_DEST: dstate_nxt = D_ROUTE;
      default:     dstate_nxt = D_IDLE;
    endcase
  end

  always_comb begin
    uread_en = (dstate == D_READ_DEST);
    uaddr    = vrptr[PTR_SZ-1:0];
    uaddr_in = PTR_IN_SZ'(DEST_ID_OFS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dest_id <= '0;
      vrptr   <= '0;
    end else begin
      if (dstate == D_READ_DEST) dest_id <= udata;
      if (dstate == D_ROUTE)     vrptr   <= vrptr + PTR_ONE;
    end
  end

  always_comb begin
    out_port = PORT_P1;
    drop     = 1'b0;
    case (dest_id[5:4])
      2'b01:   out_port = PORT_P1;
      2'b10:   out_port = PORT_P2;
      2'b11:   out_port = PORT_P3;
      default: begin
        out_port = PORT_P1;
`ifdef DEST_DROP_EN
        drop = 1'b1;
`endif
      end
    endcase
  end

  // A dropped packet never touches the map, so its slot stays free and retires through rptr.
  assign route_wr = (dstate == D_ROUTE) && !drop;

  assign grant[0] = rel_req[0] && !route_wr;
  assign grant[1] = rel_req[1] && !route_wr && !rel_req[0];
  assign grant[2] = rel_req[2] && !route_wr && !rel_req[0] && !rel_req[1];

  always_comb begin
    map_we    = route_wr || (|grant);
    map_wdata = route_wr ? out_port : PORT_FREE;
    if (route_wr)      map_waddr = vrptr[PTR_SZ-1:0];
    else if (grant[0]) map_waddr = slot[0];
    else if (grant[1]) map_waddr = slot[1];
    else               map_waddr = slot[2];
  end

  assign rptr_nxt = ((rptr != vrptr) && (map_rdata == PORT_FREE)) ? rptr + PTR_ONE : rptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr      <= '0;
      rptr_gray <= '0;
    end else begin
      rptr      <= rptr_nxt;
      rptr_gray <= rptr_nxt ^ (rptr_nxt >> 1);
    end
  end

  pkt_fifo_router_core_mem #(.PTR_SZ(PTR_SZ), .PTR_IN_SZ(PTR_IN_SZ), .UWIDTH(UWIDTH)) u_mem (
    .clk(clk), .write_en(write_en), .waddr(waddr), .waddr_in(waddr_in), .wdata(wdata),
    .raddr(slot), .raddr_in(raddr_in), .rdata(rdata),
    .uread_en(uread_en), .uaddr(uaddr), .uaddr_in(uaddr_in), .udata(udata)
  );

  pkt_fifo_router_core_map #(.PTR_SZ(PTR_SZ)) u_map (
    .clk(clk), .rst(rst), .we(map_we), .waddr(map_waddr), .wdata(map_wdata),
    .raddr(rptr[PTR_SZ-1:0]), .rdata(map_rdata)
  );

  for (genvar g = 0; g < 3; g++) begin : g_port
    assign push[g] = route_wr && (out_port == port_id_e'(2'(g + 1)));
    pkt_fifo_router_core_port_queue #(.PTR_SZ(PTR_SZ)) u_q (
      .clk(clk), .rst(rst), .push(push[g]), .push_slot(vrptr[PTR_SZ-1:0]),
      .done(done[g]), .grant(grant[g]), .en(en[g]), .slot(slot[g]), .rel_req(rel_req[g])
    );
  end

  assign {read_port_3_en, read_port_2_en, read_port_1_en} = en;
  assign raddr_port_1 = slot[0];
  assign raddr_port_2 = slot[1];
  assign raddr_port_3 = slot[2];
  assign rdata_port_1 = rdata[0];
  assign rdata_port_2 = rdata[1];
  assign rdata_port_3 = rdata[2];

endmodule

// File: tb/tb_pkt_fifo_router_core.sv
// Directed bench for pkt_fifo_router_core: dispatch, release ordering, arbitration, dest 00 handling, reset.
module tb_pkt_fifo_router_core;
  import pkt_fifo_router_core_pkg::*;

  logic       clk = 1'b0;
  logic       rst, write_en;
  logic [1:0] waddr;
  logic [3:0] waddr_in;
  logic [7:0] wdata;
  logic [2:0] rq2_wptr;
  logic       read_port_1_done, read_port_2_done, read_port_3_done;
  logic [3:0] raddr_in_port_1, raddr_in_port_2, raddr_in_port_3;
  logic       read_port_1_en, read_port_2_en, read_port_3_en;
  logic [1:0] raddr_port_1, raddr_port_2, raddr_port_3;
  logic [7:0] rdata_port_1, rdata_port_2, rdata_port_3;
  logic [2:0] rptr_gray;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pkt_fifo_router_core dut (
    .clk(clk), .rst(rst), .write_en(write_en), .waddr(waddr), .waddr_in(waddr_in), .wdata(wdata),
    .rq2_wptr(rq2_wptr),
    .read_port_1_done(read_port_1_done), .read_port_2_done(read_port_2_done), .read_port_3_done(read_port_3_done),
    .raddr_in_port_1(raddr_in_port_1), .raddr_in_port_2(raddr_in_port_2), .raddr_in_port_3(raddr_in_port_3),
    .read_port_1_en(read_port_1_en), .read_port_2_en(read_port_2_en), .read_port_3_en(read_port_3_en),
    .raddr_port_1(raddr_port_1), .raddr_port_2(raddr_port_2), .raddr_port_3(raddr_port_3),
    .rdata_port_1(rdata_port_1), .rdata_port_2(rdata_port_2), .rdata_port_3(rdata_port_3),
    .rptr_gray(rptr_gray)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_byte(input logic [1:0] s, input logic [3:0] i, input logic [7:0] d);
    write_en = 1'b1; waddr = s; waddr_in = i; wdata = d;
    tick(1);
    write_en = 1'b0;
  endtask

  task automatic write_packet(input logic [1:0] s, input logic [7:0] src, input logic [7:0] dest);
    write_byte(s, 4'd0, src);
    write_byte(s, 4'd1, dest);
    write_byte(s, 4'd2, 8'd2);
    write_byte(s, 4'd3, src ^ 8'h5A);
    write_byte(s, 4'd4, dest ^ 8'hA5);
    write_byte(s, 4'd5, 8'hC3);
  endtask

  task automatic pulse_done(input int p);
    read_port_1_done = (p == 1);
    read_port_2_done = (p == 2);
    read_port_3_done = (p == 3);
    tick(1);
    {read_port_1_done, read_port_2_done, read_port_3_done} = 3'b000;
  endtask

  task automatic test_reset;
    rst = 1'b1; write_en = 1'b0; waddr = '0; waddr_in = '0; wdata = '0; rq2_wptr = '0;
    {read_port_1_done, read_port_2_done, read_port_3_done} = 3'b000;
    raddr_in_port_1 = '0; raddr_in_port_2 = '0; raddr_in_port_3 = '0;
    tick(2);
    total++;
    if ({read_port_1_en, read_port_2_en, read_port_3_en} !== 3'b000) begin
      bad++; $display("FAIL reset_en: got %b want 000", {read_port_1_en, read_port_2_en, read_port_3_en});
    end
    total++;
    if (rptr_gray !== 3'b000) begin bad++; $display("FAIL reset_gray: got %b want 000", rptr_gray); end
    total++;
    if ({raddr_port_1, raddr_port_2, raddr_port_3} !== 6'd0) begin
      bad++; $display("FAIL reset_raddr: got %h want 0", {raddr_port_1, raddr_port_2, raddr_port_3});
    end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_dispatch;
    int cyc = 0;
    write_packet(2'd0, 8'h11, 8'd160);
    rq2_wptr = 3'd1;
    while (read_port_2_en !== 1'b1 && cyc < 8) begin
      tick(1);
      cyc++;
    end
    total++;
    if (read_port_2_en !== 1'b1 || cyc > 4) begin
      bad++; $display("FAIL dispatch_latency: en=%b after %0d cycles want 1 within 4", read_port_2_en, cyc);
    end
    total++;
    if (raddr_port_2 !== 2'd0) begin bad++; $display("FAIL dispatch_raddr2: got %0d want 0", raddr_port_2); end
    total++;
    if (dut.u_map.entries[0] !== PORT_P2) begin
      bad++; $display("FAIL dispatch_map0: got %0d want 2", dut.u_map.entries[0]);
    end
    total++;
    if (dut.vrptr !== 3'd1) begin bad++; $display("FAIL dispatch_vrptr: got %0d want 1", dut.vrptr); end
    raddr_in_port_2 = 4'd1;
    #1;
    total++;
    if (rdata_port_2 !== 8'd160) begin bad++; $display("FAIL dispatch_rdata_dest: got %0d want 160", rdata_port_2); end
    raddr_in_port_2 = 4'd0;
    #1;
    total++;
    if (rdata_port_2 !== 8'h11) begin bad++; $display("FAIL dispatch_rdata_src: got %h want 11", rdata_port_2); end
  endtask

  task automatic test_multi;
    write_packet(2'd1, 8'h22, 8'd16);
    write_packet(2'd2, 8'h33, 8'd160);
    rq2_wptr = 3'd3;
    tick(10);
    total++;
    if (read_port_1_en !== 1'b1 || raddr_port_1 !== 2'd1) begin
      bad++; $display("FAIL multi_port1: en=%b raddr=%0d want en=1 raddr=1", read_port_1_en, raddr_port_1);
    end
    total++;
    if (dut.u_map.entries[1] !== PORT_P1 || dut.u_map.entries[2] !== PORT_P2) begin
      bad++; $display("FAIL multi_map: map1=%0d map2=%0d want 1 2", dut.u_map.entries[1], dut.u_map.entries[2]);
    end
    total++;
    if (read_port_2_en !== 1'b1 || raddr_port_2 !== 2'd0) begin
      bad++; $display("FAIL multi_port2_head: en=%b raddr=%0d want en=1 raddr=0", read_port_2_en, raddr_port_2);
    end
    total++;
    if (dut.vrptr !== 3'd3 || rptr_gray !== 3'b000 || read_port_3_en !== 1'b0) begin
      bad++; $display("FAIL multi_ptrs: vrptr=%0d gray=%b en3=%b want 3 000 0", dut.vrptr, rptr_gray, read_port_3_en);
    end
  endtask

  task automatic test_release_p2;
    pulse_done(2);
    tick(3);
    total++;
    if (dut.u_map.entries[0] !== PORT_FREE) begin
      bad++; $display("FAIL rel2_map0: got %0d want 0", dut.u_map.entries[0]);
    end
    total++;
    if (dut.rptr !== 3'd1 || rptr_gray !== 3'b001) begin
      bad++; $display("FAIL rel2_rptr: rptr=%0d gray=%b want 1 001", dut.rptr, rptr_gray);
    end
    total++;
    if (read_port_2_en !== 1'b1 || raddr_port_2 !== 2'd2) begin
      bad++; $display("FAIL rel2_next_slot: en=%b raddr=%0d want en=1 raddr=2", read_port_2_en, raddr_port_2);
    end
  endtask

  task automatic test_release_p1_and_idle_done;
    pulse_done(1);
    tick(4);
    total++;
    if (dut.rptr !== 3'd2 || rptr_gray !== 3'b011) begin
      bad++; $display("FAIL rel1_rptr_halt: rptr=%0d gray=%b want 2 011", dut.rptr, rptr_gray);
    end
    total++;
    if (read_port_1_en !== 1'b0) begin bad++; $display("FAIL rel1_en: got %b want 0", read_port_1_en); end
    pulse_done(3);
    tick(3);
    total++;
    if (read_port_3_en !== 1'b0 || dut.rptr !== 3'd2 || dut.u_map.entries[2] !== PORT_P2) begin
      bad++; $display("FAIL idle_done3: en3=%b rptr=%0d map2=%0d want 0 2 2", read_port_3_en, dut.rptr, dut.u_map.entries[2]);
    end
  endtask

  task automatic test_simul_done;
    write_packet(2'd3, 8'h44, 8'd16);
    rq2_wptr = 3'd4;
    tick(8);
    total++;
    if (read_port_1_en !== 1'b1 || raddr_port_1 !== 2'd3) begin
      bad++; $display("FAIL simul_setup: en1=%b raddr1=%0d want 1 3", read_port_1_en, raddr_port_1);
    end
    read_port_1_done = 1'b1;
    read_port_2_done = 1'b1;
    tick(1);
    read_port_1_done = 1'b0;
    read_port_2_done = 1'b0;
    tick(1);
    total++;
    if (dut.u_map.entries[3] !== PORT_FREE || dut.u_map.entries[2] !== PORT_P2) begin
      bad++; $display("FAIL simul_p1_first: map3=%0d map2=%0d want 0 2", dut.u_map.entries[3], dut.u_map.entries[2]);
    end
    tick(1);
    total++;
    if (dut.u_map.entries[2] !== PORT_FREE) begin
      bad++; $display("FAIL simul_p2_second: map2=%0d want 0", dut.u_map.entries[2]);
    end
    tick(2);
    total++;
    if (dut.rptr !== 3'd4 || dut.vrptr !== 3'd4 || rptr_gray !== 3'b110) begin
      bad++; $display("FAIL simul_ptrs: rptr=%0d vrptr=%0d gray=%b want 4 4 110", dut.rptr, dut.vrptr, rptr_gray);
    end
    total++;
    if (dut.dstate !== D_IDLE) begin bad++; $display("FAIL simul_disp_idle: got %0d want 0", dut.dstate); end
  endtask

  task automatic test_dest_zero;
    write_packet(2'd0, 8'h55, 8'h0F);
    rq2_wptr = 3'd5;
    tick(8);
`ifdef DEST_DROP_EN
    total++;
    if ({read_port_1_en, read_port_2_en, read_port_3_en} !== 3'b000) begin
      bad++; $display("FAIL drop_en: got %b want 000", {read_port_1_en, read_port_2_en, read_port_3_en});
    end
    total++;
    if (dut.rptr !== 3'd5 || rptr_gray !== 3'b111 || dut.u_map.entries[0] !== PORT_FREE) begin
      bad++; $display("FAIL drop_rptr: rptr=%0d gray=%b map0=%0d want 5 111 0", dut.rptr, rptr_gray, dut.u_map.entries[0]);
    end
`else
    total++;
    if (read_port_1_en !== 1'b1 || raddr_port_1 !== 2'd0 || dut.u_map.entries[0] !== PORT_P1) begin
      bad++; $display("FAIL dest00_port1: en1=%b raddr1=%0d map0=%0d want 1 0 1", read_port_1_en, raddr_port_1, dut.u_map.entries[0]);
    end
    total++;
    if (dut.rptr !== 3'd4) begin bad++; $display("FAIL dest00_rptr_hold: got %0d want 4", dut.rptr); end
    pulse_done(1);
    tick(4);
    total++;
    if (dut.rptr !== 3'd5 || rptr_gray !== 3'b111) begin
      bad++; $display("FAIL dest00_rptr_wrap: rptr=%0d gray=%b want 5 111", dut.rptr, rptr_gray);
    end
`endif
  endtask

  task automatic test_reset_mid;
    rst = 1'b1;
    rq2_wptr = 3'd0;
    tick(1);
    rst = 1'b0;
    write_packet(2'd0, 8'h66, 8'h30);
    rq2_wptr = 3'd1;
    tick(6);
    total++;
    if (read_port_3_en !== 1'b1 || raddr_port_3 !== 2'd0) begin
      bad++; $display("FAIL mid_port3: en3=%b raddr3=%0d want 1 0", read_port_3_en, raddr_port_3);
    end
    rst = 1'b1;
    tick(1);
    total++;
    if (read_port_3_en !== 1'b0 || dut.u_map.entries[0] !== PORT_FREE) begin
      bad++; $display("FAIL mid_reset_own: en3=%b map0=%0d want 0 0", read_port_3_en, dut.u_map.entries[0]);
    end
    total++;
    if (dut.vrptr !== 3'd0 || rptr_gray !== 3'b000) begin
      bad++; $display("FAIL mid_reset_ptrs: vrptr=%0d gray=%b want 0 000", dut.vrptr, rptr_gray);
    end
    rq2_wptr = 3'd0;
    rst = 1'b0;
    tick(1);
  endtask

  initial begin
    test_reset;
    test_dispatch;
    test_multi;
    test_release_p2;
    test_release_p1_and_idle_done;
    test_simul_done;
    test_dest_zero;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
